// File: rtl/divider_mc_32.sv
`default_nettype none
// ============================================================================
//  Module      : divider_mc_32
//  Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Radix-2
//                restoring division on operand magnitudes, one quotient bit
//                per cycle, with the sign fix-up applied in a final cycle.
//                Handshake: start (sampled in IDLE) / busy / done pulse.
//  Options     : DIV_EARLY_OUT_EN - when defined, divide-by-zero and the
//                signed-overflow pair bypass the iteration and finish with
//                done in cycle 2 instead of cycle 34.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_mc_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int                 c_cnt_w   = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               r_state;
  logic                 r_sel_rem;   // op[1]: 1 selects the remainder
  logic                 r_qneg;      // quotient must be negated in FIX
  logic                 r_rneg;      // remainder must be negated in FIX
  logic [WIDTH-1:0]     r_div;       // divisor magnitude
  logic [WIDTH-1:0]     r_quo;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]     r_rem;       // partial remainder
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_signed;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_remsh;
  logic [WIDTH+1:0]     w_trial;
  logic                 w_trial_ok;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Operand magnitudes and one restoring step. The shifted remainder can
  // reach 33 bits, so the trial subtraction carries one extra bit to keep
  // its borrow; a 0x80000000 magnitude is simply treated as unsigned.
  always_comb begin
    w_signed   = ~op[0];
    w_b_zero   = (b == '0);
    w_a_mag    = (w_signed && a[WIDTH-1]) ? -a : a;
    w_b_mag    = (w_signed && b[WIDTH-1]) ? -b : b;
    w_remsh    = {r_rem, r_quo[WIDTH-1]};
    w_trial    = {1'b0, w_remsh} - {2'b00, r_div};
    w_trial_ok = ~w_trial[WIDTH+1];
    w_quo_fix  = r_qneg ? -r_quo : r_quo;
    w_rem_fix  = r_rneg ? -r_rem : r_rem;
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel_rem <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_div     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel_rem <= op[1];
            r_div     <= w_b_mag;
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_cnt     <= '0;
            // Quotient sign is left alone on divide-by-zero so the all-ones
            // magnitude reads back as -1 / 0xFFFFFFFF.
            r_qneg    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & ~w_b_zero;
            r_rneg    <= w_signed & a[WIDTH-1];
            busy      <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            // Preload the magnitudes the iteration would have produced and
            // let FIX apply the same sign rules, so results match exactly.
            if (w_b_zero) begin
              r_quo   <= '1;
              r_rem   <= w_a_mag;
              r_state <= S_FIX;
            end else if (w_signed && (a == c_int_min) && (b == '1)) begin
              r_quo   <= c_int_min;
              r_rem   <= '0;
              r_state <= S_FIX;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state   <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
          r_rem <= w_trial_ok ? w_trial[WIDTH-1:0] : w_remsh[WIDTH-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          result  <= r_sel_rem ? w_rem_fix : w_quo_fix;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_mc_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_mc_32
//  Description : Self-checking bench for divider_mc_32. Directed RV32M corner
//                cases plus randomized operations against an arithmetic
//                reference model; checks result, done cycle, done count and
//                busy profile. Honours DIV_EARLY_OUT_EN for expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_mc_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  divider_mc_32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sx / sy;
      end
      2'b01: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 0) return 2;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`endif
    return 34;
  endfunction

  // Issue one operation and watch 40 cycles. inj: cycle in which a stray
  // start is pulsed (0 = none). abort_at: cycle in which reset is asserted.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int inj, input int abort_at);
    int          lat;
    int          ndone;
    int          dcyc;
    int          busy_bad;
    bit          aborted;
    logic [31:0] exp;
    lat      = ref_latency(o, x, y);
    exp      = ref_div(o, x, y);
    ndone    = 0;
    dcyc     = 0;
    busy_bad = 0;
    aborted  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) dcyc = cyc;
      end
      if (!aborted && (busy !== (cyc <= lat))) busy_bad++;
      if (aborted && busy !== 1'b0) busy_bad++;
      if (abort_at == cyc) begin
        reset = 1'b1;
        #1;
        check({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_abort_done"}, {31'd0, done}, 32'd0);
        check({tag, "_abort_result"}, result, 32'd0);
        aborted = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      start = (inj != 0 && cyc == inj);
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
    end
    start = 1'b0;
    check({tag, "_busy_profile"}, busy_bad, 0);
    if (aborted) begin
      check({tag, "_done_count"}, ndone, 0);
    end else begin
      check({tag, "_done_count"}, ndone, 1);
      check({tag, "_done_cycle"}, dcyc, lat);
      check({tag, "_result"}, result, exp);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0, 0);
    do_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 0, 0);
    do_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 0, 0);
    do_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 0, 0);
    do_op("divu_by0", 2'b01, 32'h1234_5678, 32'd0, 0, 0);
    do_op("div_by0", 2'b00, 32'h1234_5678, 32'd0, 0, 0);
    do_op("remu_by0", 2'b11, 32'h1234_5678, 32'd0, 0, 0);
    do_op("rem_by0", 2'b10, 32'h1234_5678, 32'd0, 0, 0);
    do_op("div_neg_by0", 2'b00, 32'h8765_4321, 32'd0, 0, 0);
    do_op("rem_neg_by0", 2'b10, 32'h8765_4321, 32'd0, 0, 0);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op("divu_ovf_pair", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op("divu_stray_start", 2'b01, 32'd1000, 32'd33, 10, 0);
    do_op("rem_stray_start", 2'b10, 32'hFFFF_F000, 32'd77, 10, 0);
    do_op("divu_abort", 2'b01, 32'd5000, 32'd3, 0, 15);
    do_op("divu_max_by1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      case ($urandom_range(0, 9))
        0:       ry = 32'd0;
        1:       ry = 32'hFFFF_FFFF;
        2, 3:    ry = $urandom_range(1, 15);
        4:       ry = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      do_op($sformatf("rand%0d", i), ro, rx, ry, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider_mc_32.md
Name: divider_mc_32

Overview:
Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the single-cycle ALU and supplies the divide/remainder results that the single-cycle path cannot produce. It uses a start/busy/done handshake so the core control FSM can stall until the result is ready. The algorithm is radix-2 restoring division on magnitudes, with sign fix-up at the end.

Parameters:
WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
a  input  32  dividend (rs1); captured on an accepted start
b  input  32  divisor (rs2); captured on an accepted start
busy  output  1  high from the cycle after an accepted start until done is asserted (inclusive)
done  output  1  single-cycle pulse; result is valid in that cycle
result  output  32  quotient or remainder selected by op; held until the next accepted start

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0; all internal registers cleared. Reset asserted mid-operation aborts it, and no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 accepts the request.
  - Latch op.
  - Latch |a| and |b| for signed ops; raw a and b for unsigned ops.
  - Latch sign flags: quotient negative = a[31]^b[31]; remainder negative = a[31] (signed ops only).
  - Clear remainder register, iteration counter=0, go to CALC.
- CALC: one restoring step per cycle.
  - {rem,quo} shifted left 1.
  - Trial = rem - divisor (33-bit).
  - If trial is non-negative: rem=trial[31:0], quo[0]=1.
  - Counter increments; after exactly 32 steps go to FIX.
- FIX: apply two's-complement negation per the sign flags, select quotient (op[1]=0) or remainder (op[1]=1) into result, go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. busy=1 in CALC, FIX and DONE.
- Latency (feature disabled): start sampled at edge 0 -> done high in cycle 34 (32 CALC + FIX + DONE). A new start is accepted in the first IDLE cycle after DONE.
- start while busy: ignored, no effect on the operation in flight. a, b and op may change freely after acceptance.
- Divide by zero (b=0), from the natural algorithm plus the required fix-up rules:
  - DIVU → 0xFFFFFFFF; DIV → 0xFFFFFFFF (-1).
  - REM/REMU → a unchanged.
  - The quotient sign fix-up is suppressed when b=0.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): DIV → 0x80000000, REM → 0. The 33-bit arithmetic must produce this without special casing; a magnitude of 0x80000000 is handled as unsigned.
- Remainder sign always follows the dividend; quotient truncates toward zero (RISC-V semantics).
- result is updated only in FIX (or the early-out path) and is stable otherwise.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, on an accepted start with b=0 or the signed-overflow pair, skip CALC.
  - Load the architectural result directly.
  - Go to DONE next cycle, so done is high in cycle 2.
  - busy timing is unchanged in form (high from cycle 1 through DONE).
- Undefined: these cases take the full 34-cycle path. Results must be identical either way.

Test Plan:
1. DIVU a=100, b=7 -> done exactly in cycle 34, result=14. Repeat with REMU -> result=2.
2. DIV a=-100 (0xFFFFFF9C), b=7 -> result=-14 (0xFFFFFFF2). REM -> result=-2 (0xFFFFFFFE). REM a=100, b=-7 -> result=2.
3. b=0, a=0x12345678: DIVU and DIV -> 0xFFFFFFFF; REMU and REM -> 0x12345678. With DIV_EARLY_OUT_EN defined, done arrives in cycle 2.
4. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM -> 0. DIVU with the same operands -> 0.
5. Pulse start with new operands at cycle 10 of a busy operation -> ignored. The original result and timing are unchanged, and done pulses once.
6. Assert reset at cycle 15 of an operation -> busy=0, done=0, result=0 immediately; no done follows. A subsequent DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
